// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared playfield grid constants
package tetris_pkg;

    localparam int GRID_COLS   = 10;
    localparam int GRID_ROWS   = 20;
    localparam int CELL_W      = 8;
    localparam int GRID_ADDR_W = 8;

    localparam logic [CELL_W-1:0] EMPTY_CELL = '0;

endpackage

// File: rtl/line_clear_engine_if.sv
// rtl/line_clear_engine_if.sv - grid memory write/read port A bundle
interface line_clear_engine_if import tetris_pkg::*; #(
    parameter int ADDR_W = GRID_ADDR_W,
    parameter int DATA_W = CELL_W
);

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q;

    modport master (
        output mem_addr,
        output mem_data,
        output mem_we,
        input  mem_q
    );

    modport slave (
        input  mem_addr,
        input  mem_data,
        input  mem_we,
        output mem_q
    );

endinterface

// File: rtl/grid_addr_gen.sv
// rtl/grid_addr_gen.sv - (row, col) to linear grid address
module grid_addr_gen import tetris_pkg::*; #(
    parameter int COLS   = GRID_COLS,
    parameter int ADDR_W = GRID_ADDR_W
) (
    input  logic [4:0]        row_i,
    input  logic [3:0]        col_i,
    output logic [ADDR_W-1:0] addr_o
);

    // ROWS*COLS fits the address width, so the product never wraps
    assign addr_o = ADDR_W'(row_i) * ADDR_W'(COLS) + ADDR_W'(col_i);

endmodule

// File: rtl/line_clear_engine.sv
// rtl/line_clear_engine.sv - post-lock full-row detect and collapse sequencer
module line_clear_engine import tetris_pkg::*; #(
    parameter int COLS   = GRID_COLS,
    parameter int ROWS   = GRID_ROWS,
    parameter int DATA_W = CELL_W,
    parameter int ADDR_W = GRID_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           lines_cleared,
    line_clear_engine_if.master  mem
);

    typedef enum logic [2:0] {
        IDLE, SCAN_RD, SCAN_CHK, SHIFT_RD, SHIFT_WR, CLR_TOP, FIN
    } state_e;

    localparam logic [4:0] ROW_LAST  = 5'(ROWS - 1);
    localparam logic [3:0] COL_LAST  = 4'(COLS - 1);
    localparam logic [4:0] LINES_MAX = 5'(ROWS);

    state_e     state_q, state_d;
    logic [4:0] row_q, row_d;
    logic [3:0] col_q, col_d;
    logic [4:0] r_q, r_d;
    logic [4:0] lines_q, lines_d;
    logic [4:0] addr_row;
    logic [3:0] addr_col;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            r_q     <= '0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            r_q     <= r_d;
            lines_q <= lines_d;
        end
    end

    // col_q doubles as the column index of the shift and top-clear loops
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        r_d          = r_q;
        lines_d      = lines_q;
        addr_row     = '0;
        addr_col     = '0;
        mem.mem_we   = 1'b0;
        mem.mem_data = DATA_W'(EMPTY_CELL);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN_RD;
                    row_d   = ROW_LAST;
                    col_d   = '0;
                    lines_d = '0;
                end
            end
            SCAN_RD: begin
                addr_row = row_q;
                addr_col = col_q;
                state_d  = SCAN_CHK;
            end
            SCAN_CHK: begin
                addr_row = row_q;
                addr_col = col_q;
                if (mem.mem_q == DATA_W'(EMPTY_CELL)) begin
                    if (row_q == '0) begin
                        state_d = FIN;
                    end else begin
                        row_d   = row_q - 5'd1;
                        col_d   = '0;
                        state_d = SCAN_RD;
                    end
                end else if (col_q != COL_LAST) begin
                    col_d   = col_q + 4'd1;
                    state_d = SCAN_RD;
                end else begin
                    if (lines_q != LINES_MAX) begin
                        lines_d = lines_q + 5'd1;
                    end
                    r_d     = row_q;
                    col_d   = '0;
                    state_d = (row_q != '0) ? SHIFT_RD : CLR_TOP;
                end
            end
            SHIFT_RD: begin
                addr_row = r_q - 5'd1;
                addr_col = col_q;
                state_d  = SHIFT_WR;
            end
            SHIFT_WR: begin
                addr_row     = r_q;
                addr_col     = col_q;
                mem.mem_we   = 1'b1;
                mem.mem_data = mem.mem_q;
                if (col_q != COL_LAST) begin
                    col_d   = col_q + 4'd1;
                    state_d = SHIFT_RD;
                end else begin
                    col_d   = '0;
                    r_d     = r_q - 5'd1;
                    state_d = (r_q != 5'd1) ? SHIFT_RD : CLR_TOP;
                end
            end
            CLR_TOP: begin
                addr_col   = col_q;
                mem.mem_we = 1'b1;
                if (col_q != COL_LAST) begin
                    col_d = col_q + 4'd1;
                end else begin
                    // the row that dropped into row_q may itself be full
                    col_d   = '0;
                    state_d = SCAN_RD;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    grid_addr_gen #(
        .COLS   (COLS),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .row_i  (addr_row),
        .col_i  (addr_col),
        .addr_o (mem.mem_addr)
    );

    assign busy          = (state_q != IDLE) && (state_q != FIN);
    assign done          = (state_q == FIN);
    assign lines_cleared = lines_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// tb/tb_line_clear_engine.sv - scoreboard bench for line_clear_engine
module tb_line_clear_engine;
    import tetris_pkg::*;

    localparam int COLS  = GRID_COLS;
    localparam int ROWS  = GRID_ROWS;
    localparam int DW    = CELL_W;
    localparam int AW    = GRID_ADDR_W;
    localparam int NCELL = ROWS * COLS;
    localparam int BOUND = 20000;

    typedef struct {
        string tag;
        int    lines;
        int    busy_cycles;
        int    we_cycles;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic [4:0] lines_cleared;
    logic       load_req;

    logic [DW-1:0] grid    [0:(1<<AW)-1];
    logic [DW-1:0] img     [0:NCELL-1];
    logic [DW-1:0] exp_img [0:NCELL-1];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    line_clear_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    line_clear_engine #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .mem           (bus)
    );

    // grid memory model: registered read, one-cycle latency
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < NCELL; i++) grid[i] <= img[i];
        end else if (bus.mem_we) begin
            grid[bus.mem_addr] <= bus.mem_data;
        end
        bus.mem_q <= grid[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < NCELL; i++) img[i] = '0;
    endtask

    task automatic fill_row(input int r, input logic [DW-1:0] v);
        for (int c = 0; c < COLS; c++) img[r*COLS + c] = v;
    endtask

    // reference: keep non-full rows in order, packed to the bottom
    function automatic int ref_clear();
        int  dst = ROWS - 1;
        int  n   = 0;
        bit  full;
        for (int r = ROWS - 1; r >= 0; r--) begin
            full = 1'b1;
            for (int c = 0; c < COLS; c++) if (img[r*COLS + c] == '0) full = 1'b0;
            if (full) begin
                n++;
            end else begin
                for (int c = 0; c < COLS; c++) exp_img[dst*COLS + c] = img[r*COLS + c];
                dst--;
            end
        end
        for (int r = dst; r >= 0; r--)
            for (int c = 0; c < COLS; c++) exp_img[r*COLS + c] = '0;
        return (n > ROWS) ? ROWS : n;
    endfunction

    function automatic logic [127:0] row_bits(input int r, input bit from_exp);
        logic [127:0] v = '0;
        for (int c = 0; c < COLS; c++)
            v[c*DW +: DW] = from_exp ? exp_img[r*COLS + c] : grid[r*COLS + c];
        return v;
    endfunction

    task automatic load_grid();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic run_pass(input string tag, input int exp_busy, input int exp_we, input bit mid_start);
        exp_t e;
        int   busy_cnt = 0;
        int   we_cnt   = 0;
        bit   got      = 1'b0;
        sb.push_back('{tag, ref_clear(), exp_busy, exp_we});
        load_grid();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < BOUND; cyc++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (bus.mem_we) we_cnt++;
            start = mid_start && (cyc == 5);
            @(negedge clk);
        end
        start = 1'b0;
        e = sb.pop_front();
        check({e.tag, "_done_seen"}, 128'(got), 128'(1));
        if (got) begin
            check({e.tag, "_lines"}, 128'(lines_cleared), 128'(e.lines));
            check({e.tag, "_busy_at_done"}, 128'(busy), 128'(0));
            if (e.busy_cycles >= 0) check({e.tag, "_busy_cycles"}, 128'(busy_cnt), 128'(e.busy_cycles));
            if (e.we_cycles >= 0) check({e.tag, "_we_cycles"}, 128'(we_cnt), 128'(e.we_cycles));
            for (int r = 0; r < ROWS; r++)
                check($sformatf("%s_row%0d", e.tag, r), row_bits(r, 1'b0), row_bits(r, 1'b1));
            @(negedge clk);
            check({e.tag, "_done_pulse"}, 128'(done), 128'(0));
            check({e.tag, "_lines_held"}, 128'(lines_cleared), 128'(e.lines));
        end
    endtask

    initial begin
        bit hit;
        reset    = 1'b1;
        start    = 1'b0;
        load_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_lines", 128'(lines_cleared), 128'(0));
        check("rst_addr", 128'(bus.mem_addr), 128'(0));
        check("rst_data", 128'(bus.mem_data), 128'(0));
        check("rst_we", 128'(bus.mem_we), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        clear_img();
        run_pass("empty", 2*ROWS, 0, 1'b0);

        clear_img();
        fill_row(ROWS-1, 8'd3);
        img[(ROWS-2)*COLS] = 8'd5;
        run_pass("single", 20 + 2*COLS*(ROWS-1) + COLS + 4 + 2*(ROWS-1), COLS*(ROWS-1) + COLS, 1'b0);

        clear_img();
        for (int r = ROWS-4; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) img[r*COLS + c] = DW'(c + 1);
        img[(ROWS-5)*COLS] = 8'd7;
        run_pass("tetris", -1, -1, 1'b0);

        clear_img();
        fill_row(ROWS-1, 8'd4);
        fill_row(ROWS-3, 8'd6);
        for (int c = 0; c < COLS-1; c++) img[(ROWS-2)*COLS + c] = DW'(c + 10);
        img[(ROWS-4)*COLS + 2] = 8'd9;
        img[(ROWS-4)*COLS + 7] = 8'd1;
        run_pass("split", -1, -1, 1'b0);

        clear_img();
        fill_row(0, 8'd2);
        run_pass("top_row", 2*(ROWS-1) + 2*COLS + COLS + 2, COLS, 1'b1);
        repeat (3) @(negedge clk);
        check("top_row_no_requeue", 128'(busy), 128'(0));

        clear_img();
        for (int r = 0; r < ROWS; r++) fill_row(r, DW'(r + 1));
        run_pass("all_full", -1, -1, 1'b0);

        clear_img();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) img[r*COLS + c] = DW'($urandom_range(255, 1));
            if ($urandom_range(2, 0) != 0) img[r*COLS + $urandom_range(COLS-1, 0)] = '0;
        end
        run_pass("random", -1, -1, 1'b0);

        clear_img();
        fill_row(ROWS-1, 8'd8);
        img[(ROWS-2)*COLS + 3] = 8'd1;
        load_grid();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int cyc = 0; cyc < BOUND; cyc++) begin
            if (bus.mem_we) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_reached_shift", 128'(hit), 128'(1));
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_we", 128'(bus.mem_we), 128'(0));
        check("abort_lines", 128'(lines_cleared), 128'(0));
        check("abort_addr_idle", 128'(bus.mem_addr), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        run_pass("after_abort", -1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
